// File: rtl/dm_port_arbiter.sv
// Two-port arbiter for the single data-memory port: CPU (port 0) has priority,
// the DMA port (port 1) gets a forced grant after MAX_WAIT consecutive losses.
module dm_port_arbiter #(
   parameter int         MAX_WAIT = 4,
   parameter int         WAIT_W   = 3,
   parameter logic [2:0] DM_W     = 3'd0,
   parameter logic [2:0] DM_H     = 3'd1,
   parameter logic [2:0] DM_B     = 3'd2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0,
   input  logic [31:0] addr0,
   input  logic [31:0] wdata0,
   input  logic [2:0]  op0,
   input  logic        we0,
   input  logic        req1,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata1,
   input  logic [2:0]  op1,
   input  logic        we1,
   output logic        done0,
   output logic        err0,
   output logic        done1,
   output logic        err1,
   output logic [31:0] rdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_byteen,
   output logic        mem_en,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t              state_q, state_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic                gnt_q;
   logic [31:0]         addr_q, wdata_q;
   logic [2:0]          op_q;
   logic                we_q, err_q;

   logic                any_req, grant1, bad;
   logic [3:0]          lane_be;
   logic [31:0]         lane_wd;

   assign any_req = req0 | req1;
   assign grant1  = req1 & ((wait_q == WAIT_W'(MAX_WAIT)) | ~req0);

   // NOTE: every signal written in an always_comb gets a default first, so no path can leave it unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      case (state_q)
         IDLE: begin
            if (!req1 || grant1)
               wait_d = '0;
            else if (wait_q != WAIT_W'(MAX_WAIT))
               wait_d = wait_q + 1'b1;
            if (any_req)
               state_d = ACCESS;
         end
         ACCESS:  state_d = RESP;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   // NOTE: the latched request is reset too, because the memory-port outputs are driven straight from it and must read 0 in reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         gnt_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         op_q    <= '0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
      end else if (state_q == IDLE && any_req) begin
         gnt_q   <= grant1;
         addr_q  <= grant1 ? addr1  : addr0;
         wdata_q <= grant1 ? wdata1 : wdata0;
         op_q    <= grant1 ? op1    : op0;
         we_q    <= grant1 ? we1    : we0;
      end else if (state_q == ACCESS) begin
         err_q   <= bad;
      end
   end

   // Alignment check and lane placement, evaluated on the latched request.
   always_comb begin
      bad     = 1'b0;
      lane_be = 4'b0000;
      lane_wd = wdata_q;
      if (op_q == DM_W) begin
         bad     = (addr_q[1:0] != 2'b00);
         lane_be = 4'b1111;
      end else if (op_q == DM_H) begin
         bad     = addr_q[0];
         lane_be = addr_q[1] ? 4'b1100 : 4'b0011;
         lane_wd = addr_q[1] ? {wdata_q[15:0], 16'h0000} : {16'h0000, wdata_q[15:0]};
      end else if (op_q == DM_B) begin
         lane_be = 4'b0001 << addr_q[1:0];
         lane_wd = {24'h000000, wdata_q[7:0]} << {addr_q[1:0], 3'b000};
      end else begin
         bad     = 1'b1;
      end
   end

   assign mem_addr   = {addr_q[31:2], 2'b00};
   assign mem_en     = (state_q == ACCESS) & ~bad;
   assign mem_byteen = (mem_en & we_q) ? lane_be : 4'b0000;
   assign mem_wdata  = (~bad & we_q) ? lane_wd : wdata_q;

   assign done0 = (state_q == RESP) & ~gnt_q;
   assign done1 = (state_q == RESP) &  gnt_q;
   assign err0  = done0 & err_q;
   assign err1  = done1 & err_q;
   assign rdata = ((state_q == RESP) && !err_q) ? mem_rdata : 32'h0;

endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Arbitrates the single data-memory port between two requesters: the CPU M-stage (port 0) and the DMA/boot loader (port 1).
- Sequences each access as IDLE → ACCESS → RESP.
- Generates byte enables and lane-shifted write data from the DM_w/DM_h/DM_b op codes in const.v, and rejects misaligned accesses.
- CPU has priority; a wait counter stops the DMA port from being starved.

Parameters:
- MAX_WAIT, 4: number of consecutive cycles port 1 loses arbitration in IDLE before it is forced to win the next grant.
- WAIT_W, 3: width of the wait counter; must satisfy 2^WAIT_W > MAX_WAIT.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0 / req1  in  1  access request; must be held, with its fields stable, until the matching done.
- addr0 / addr1  in  32  byte address.
- wdata0 / wdata1  in  32  store data, right-justified.
- op0 / op1  in  3  DM_w, DM_h or DM_b.
- we0 / we1  in  1  1 = store, 0 = load.
- done0 / done1  out  1  one-cycle completion pulse.
- err0 / err1  out  1  valid with done: access was misaligned or used an illegal op.
- rdata  out  32  raw memory word; valid while done0 or done1 is high.
- mem_addr  out  32  word address {addr[31:2], 2'b00}.
- mem_wdata  out  32  lane-shifted store data.
- mem_byteen  out  4  byte write enables.
- mem_en  out  1  memory access strobe.
- mem_rdata  in  32  memory read data; synchronous RAM, valid the cycle after mem_en.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, wait counter=0.
  - All outputs 0, including the latched request.
  - Reset mid-access aborts the access with no done pulse; the requester re-requests.
- IDLE:
  - Neither req high: stay in IDLE.
  - Arbitration:
    - wait counter == MAX_WAIT and req1: grant port 1.
    - else req0: grant port 0.
    - else req1: grant port 1.
  - Wait counter:
    - Port 1 granted: clear to 0.
    - req1 high but port 0 granted: increment, saturating at MAX_WAIT.
    - req1 low: clear to 0.
  - On grant: latch winner id, addr, wdata, op, we; then go to ACCESS.
- ACCESS (exactly one cycle):
  - Legal access:
    - mem_en=1.
    - mem_addr from the latched addr.
    - mem_byteen and mem_wdata per the lane rules below when we=1.
    - mem_byteen=0 and mem_wdata=latched wdata when we=0.
  - Misaligned or illegal op: mem_en=0, mem_byteen=0, error flag latched.
  - Always go to RESP.
- RESP (exactly one cycle):
  - done of the granted port = 1; err of that port = latched error flag.
  - rdata = mem_rdata (0 on error).
  - Return to IDLE.
  - A req still high in the following IDLE cycle is treated as a new request.
- Lane rules (byte lane k = bits 8k+7:8k):
  - w: byteen 1111, data unshifted.
  - h: addr[1]=0 gives byteen 0011 and data {16'h0, wd[15:0]}; addr[1]=1 gives byteen 1100 and data {wd[15:0], 16'h0}.
  - b: byteen = 0001 << addr[1:0]; data = wd[7:0] in lane addr[1:0], zeros elsewhere.
- Misalignment: w with addr[1:0]≠00; h with addr[0]=1; any op other than w/h/b.
- Outside ACCESS: mem_en=0 and mem_byteen=0.
- Throughput: one access per 3 cycles; latency from req to done is 3 cycles when the port wins immediately.
- Within one access, done and err are never asserted for both ports.

Test Plan:
1. After reset, req0=1, we0=1, op0=DM_b, addr0=0x0000_1003, wdata0=0x0000_00A5 → ACCESS cycle shows mem_addr=0x1000, mem_byteen=1000, mem_wdata=0xA500_0000; done0 pulses 3 cycles after req with err0=0.
2. req0 load DM_w at 0x2000 with memory word 0xDEAD_BEEF → mem_byteen=0000, mem_en=1; in the done0 cycle rdata=0xDEAD_BEEF.
3. Store DM_h at addr 0x0002 and DM_w at addr 0x0001 → the DM_h access gives byteen 1100 and data {wd[15:0], 16'h0}; the DM_w access gives mem_en=0 and a done pulse with err=1.
4. req0 and req1 asserted together in the same cycle → port 0 is served first; port 1 completes 3 cycles later.
5. req0 re-asserted continuously with req1 held high, MAX_WAIT=4 → port 1 is granted no later than its 5th IDLE evaluation; the counter then reads 0.
6. reset driven low during ACCESS → all outputs read 0 immediately with no done pulse; after release, a held req0 is served from IDLE.
